// File: rtl/branch_target_cache_pkg.sv
// Shared types and constants for the IF-stage branch target cache.
package branch_target_cache_pkg;

  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned BTB_TAG_W   = 6;

  // One table entry: valid, partial tag, target address, taken bit.
  typedef struct packed {
    logic                 v;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          ta;
    logic                 t;
  } cache_branch_t;

  // Sequential fall-through address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_target_cache_sat_counter.sv
// Saturating up-counter used for performance statistics.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count increments, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_cache.sv
// Direct-mapped branch target cache: combinational lookup of the fetch PC,
// update from MEM-stage resolution, mispredict/redirect and perf counters.
module branch_target_cache
  import branch_target_cache_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES,
  parameter int unsigned TAG_W   = BTB_TAG_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic             upd_is_jump,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] perf_lookups,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

  cache_branch_t table_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  cache_branch_t    if_entry;
  cache_branch_t    upd_entry;
  logic             upd_hit;
  logic             unused_pc_bits;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[TAG_HI:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[TAG_HI:IDX_W+2];

  // Byte offset and PC bits above the tag do not take part in lookup.
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1],
                            upd_pc[1:0], upd_pc[31:TAG_HI+1]};

  // Lookup sees the table as it was before this cycle's update.
  always_comb begin
    if_entry    = table_q[if_idx];
    pred_hit    = if_entry.v && (if_entry.tag == if_tag);
    pred_taken  = pred_hit && if_entry.t;
    pred_target = pred_taken ? if_entry.ta : pc_plus4(if_pc);
  end

  // Resolution check drives the same-cycle PC redirect; silenced in reset.
  always_comb begin
    mispredict  = !rst && upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : pc_plus4(upd_pc);
  end

  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.v && (upd_entry.tag == upd_tag);

  // Table maintenance: flush beats update; allocate only on taken or jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i].v <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        table_q[upd_idx].t <= upd_taken || upd_is_jump;
        if (upd_taken) begin
          table_q[upd_idx].ta <= upd_target;
        end
      end else if (upd_taken || upd_is_jump) begin
        table_q[upd_idx].v   <= 1'b1;
        table_q[upd_idx].tag <= upd_tag;
        table_q[upd_idx].ta  <= upd_target;
        table_q[upd_idx].t   <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_lookup_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_valid),
    .count (perf_lookups)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict),
    .count (perf_mispredicts)
  );

endmodule

// File: tb/tb_branch_target_cache.sv
// Directed self-checking bench for branch_target_cache (32-bit and 4-bit counter builds).
module tb_branch_target_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic        upd_is_jump;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_lookups;
  logic [31:0] perf_mispredicts;

  logic        unused_hit4;
  logic        unused_taken4;
  logic [31:0] unused_target4;
  logic        unused_mis4;
  logic [31:0] unused_redirect4;
  logic [3:0]  lookups4;
  logic [3:0]  mispredicts4;

  int n_checks = 0;
  int n_errors = 0;
  int exp_look = 0;
  int exp_mis  = 0;

  always #5 clk = ~clk;

  branch_target_cache dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_is_jump      (upd_is_jump),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_lookups     (perf_lookups),
    .perf_mispredicts (perf_mispredicts)
  );

  branch_target_cache #(.CNT_W(4)) dut4 (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_hit         (unused_hit4),
    .pred_taken       (unused_taken4),
    .pred_target      (unused_target4),
    .upd_valid        (upd_valid),
    .upd_is_jump      (upd_is_jump),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (unused_mis4),
    .redirect_pc      (unused_redirect4),
    .perf_lookups     (lookups4),
    .perf_mispredicts (mispredicts4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_upd();
    upd_valid       = 1'b0;
    upd_is_jump     = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic jump, input logic taken,
                         input logic [31:0] target, input logic ptaken,
                         input logic [31:0] ptarget);
    upd_valid       = 1'b1;
    upd_is_jump     = jump;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptarget;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] target);
    if_pc = pc;
    #1;
    check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, taken});
    check({tag, "_target"}, pred_target, target);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = 32'h100;
    idle_upd();
    tick(); tick();

    // Reset state, with a mispredicting update held during reset
    set_upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    lookup("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    check("rst_lookups", perf_lookups, 32'd0);
    check("rst_mispreds", perf_mispredicts, 32'd0);
    tick();
    idle_upd();
    rst = 1'b0;
    lookup("rst_discard", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();

    // Taken update allocates; not visible until the next cycle
    set_upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    check("alloc_redirect", redirect_pc, 32'h200);
    lookup("alloc_same_cycle", 32'h100, 1'b0, 1'b0, 32'h104);
    tick(); exp_mis++;
    idle_upd();
    lookup("alloc_next", 32'h100, 1'b1, 1'b1, 32'h200);
    check("alloc_mis_cnt", perf_mispredicts, exp_mis);

    // Not-taken update on a hit clears T, keeps the entry
    set_upd(32'h100, 1'b0, 1'b0, 32'h300, 1'b1, 32'h200);
    #1;
    check("nt_mispredict", {31'd0, mispredict}, 32'd1);
    check("nt_redirect", redirect_pc, 32'h104);
    tick(); exp_mis++;
    idle_upd();
    lookup("nt_next", 32'h100, 1'b1, 1'b0, 32'h104);

    // Taken with a different target: mispredict and TA refresh
    set_upd(32'h100, 1'b0, 1'b1, 32'h240, 1'b1, 32'h200);
    #1;
    check("ta_mispredict", {31'd0, mispredict}, 32'd1);
    check("ta_redirect", redirect_pc, 32'h240);
    tick(); exp_mis++;
    idle_upd();
    lookup("ta_next", 32'h100, 1'b1, 1'b1, 32'h240);

    // Correct predictions do not mispredict
    set_upd(32'h100, 1'b0, 1'b1, 32'h240, 1'b1, 32'h240);
    #1;
    check("ok_taken", {31'd0, mispredict}, 32'd0);
    set_upd(32'h100, 1'b0, 1'b0, 32'h500, 1'b0, 32'h600);
    #1;
    check("ok_not_taken", {31'd0, mispredict}, 32'd0);
    idle_upd();
    check("ok_mis_cnt", perf_mispredicts, exp_mis);

    // Alias at 0x100 + ENTRIES*4 replaces the entry
    set_upd(32'h140, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    tick(); exp_mis++;
    idle_upd();
    lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("alias_new", 32'h140, 1'b1, 1'b1, 32'h500);

    // Not-taken miss leaves the aliased entry alone
    set_upd(32'h180, 1'b0, 1'b0, 32'h700, 1'b0, 32'h0);
    tick();
    idle_upd();
    lookup("ntmiss_180", 32'h180, 1'b0, 1'b0, 32'h184);
    lookup("ntmiss_140", 32'h140, 1'b1, 1'b1, 32'h500);

    // Jump allocation; low PC bits ignored on lookup
    set_upd(32'h1C4, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40);
    tick();
    idle_upd();
    lookup("jump", 32'h1C6, 1'b1, 1'b1, 32'h40);

    // PC+4 wraps
    lookup("wrap_lookup", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    set_upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    #1;
    check("wrap_redirect", redirect_pc, 32'h0);
    tick(); exp_mis++;
    idle_upd();

    // Flush with a same-cycle update: update dropped, mispredict counted
    flush = 1'b1;
    set_upd(32'h200, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    #1;
    check("flush_mispredict", {31'd0, mispredict}, 32'd1);
    tick(); exp_mis++;
    flush = 1'b0;
    idle_upd();
    lookup("flush_1c4", 32'h1C4, 1'b0, 1'b0, 32'h1C8);
    lookup("flush_140", 32'h140, 1'b0, 1'b0, 32'h144);
    lookup("flush_200", 32'h200, 1'b0, 1'b0, 32'h204);
    check("flush_mis_cnt", perf_mispredicts, exp_mis);

    // Lookup counting
    check("look_cnt_zero", perf_lookups, 32'd0);
    if_valid = 1'b1;
    repeat (5) tick();
    exp_look = 5;
    if_valid = 1'b0;
    check("look_cnt", perf_lookups, exp_look);

    // Asynchronous reset mid-stream clears everything at once
    set_upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    tick(); exp_mis++;
    idle_upd();
    lookup("pre_rst", 32'h100, 1'b1, 1'b1, 32'h200);
    check("pre_rst_mis_cnt", perf_mispredicts, exp_mis);
    rst = 1'b1;
    #1;
    check("async_hit", {31'd0, pred_hit}, 32'd0);
    check("async_target", pred_target, 32'h104);
    check("async_lookups", perf_lookups, 32'd0);
    check("async_mispreds", perf_mispredicts, 32'd0);
    check("async_lookups4", {28'd0, lookups4}, 32'd0);
    tick();
    rst = 1'b0;
    exp_look = 0;
    exp_mis  = 0;
    tick();

    // Saturation on the 4-bit build; 32-bit build keeps counting exactly
    if_valid = 1'b1;
    repeat (20) tick();
    if_valid = 1'b0;
    exp_look = 20;
    check("sat_lookups32", perf_lookups, exp_look);
    check("sat_lookups4", {28'd0, lookups4}, 32'hF);
    repeat (20) begin
      set_upd(32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
      tick();
      exp_mis++;
    end
    idle_upd();
    check("sat_mis32", perf_mispredicts, exp_mis);
    check("sat_mis4", {28'd0, mispredicts4}, 32'hF);
    check("sat_lookups4_hold", {28'd0, lookups4}, 32'hF);
    lookup("sat_no_alloc", 32'h300, 1'b0, 1'b0, 32'h304);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
